// File: rtl/digit_text_source_if.sv
// VGA timing stream shared by the on-screen character sources and their renderers.
// The producer drives the counters and blanking; consumers only observe them.
interface vga_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        vblnk;

    modport master (output hcount, vcount, vblnk);
    modport slave  (input  hcount, vcount, vblnk);
    modport in     (input  hcount, vcount, vblnk);
endinterface

// File: rtl/digit_text_source.sv
// Converts a binary count into four decimal characters with a sequential double-dabble
// and presents them cell by cell, LEAD clocks early, to a paired draw_char.
module digit_text_source #(
    parameter int XPOS      = 0,
    parameter int YPOS      = 0,
    parameter int PRESCALER = 1,
    parameter int LEAD      = 2,
    parameter int BLANK_LZ  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    vga_if.in           in,
    output logic [11:0] char_code,
    output logic [11:0] char_xpos,
    output logic [11:0] char_ypos,
    output logic        busy
);

    localparam logic [11:0] CELL_W    = 12'(8 * PRESCALER);
    localparam logic [11:0] CELL0_AT  = 12'(XPOS - LEAD);
    localparam logic [11:0] XPOS_12   = 12'(XPOS);
    localparam logic [11:0] LEAD_12   = 12'(LEAD);
    localparam logic [13:0] MAX_VALUE = 14'd9999;
    localparam logic [6:0]  ASCII_SPC = 7'h20;
    localparam logic [6:0]  ASCII_0   = 7'h30;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t      state, state_nxt;
    logic        vblnk_q;
    logic        trigger;
    logic [3:0]  bit_cnt;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic [15:0] disp;
    logic [6:0]  digit_code [4];
    logic [2:0]  cell_idx;
    logic [11:0] next_at;

    // Vertical position is handled by draw_char through char_ypos.
    logic unused_vcount;
    assign unused_vcount = ^in.vcount;

    // NOTE: every clocked process uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q <= 1'b0;
            trigger <= 1'b0;
        end else begin
            vblnk_q <= in.vblnk;
            trigger <= in.vblnk & ~vblnk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = CONVERT;
            CONVERT: if (bit_cnt == 4'd0) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++)
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        return r;
    endfunction

    assign bcd_adj = dabble_adjust(bcd);

    // The display register only moves in COMMIT, so a frame never shows half a conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            disp    <= '0;
        end else begin
            case (state)
                IDLE: if (trigger) begin
                    bin     <= (value > MAX_VALUE) ? MAX_VALUE : value;
                    bcd     <= '0;
                    bit_cnt <= 4'd13;
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    bit_cnt    <= bit_cnt - 4'd1;
                end
                COMMIT:  disp <= bcd;
                default: ;
            endcase
        end
    end

    // Zero digits stay blank while everything to their left is blank; the units digit never is.
    always_comb begin
        logic       lz;
        logic [3:0] nib;
        lz  = (BLANK_LZ != 0);
        nib = '0;
        for (int k = 0; k < 4; k++) begin
            nib           = disp[4*(3-k) +: 4];
            lz            = lz && (nib == 4'd0) && (k < 3);
            digit_code[k] = lz ? ASCII_SPC : ASCII_0 + {3'b000, nib};
        end
    end

    // cell_idx names the next boundary awaited after cell 0; 0 means disarmed until the next line.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_code <= {5'b0, ASCII_SPC};
            char_xpos <= XPOS_12;
            cell_idx  <= '0;
            next_at   <= '0;
        end else if (in.hcount == CELL0_AT) begin
            char_code <= {5'b0, digit_code[0]};
            char_xpos <= XPOS_12;
            next_at   <= CELL0_AT + CELL_W;
            cell_idx  <= 3'd1;
        end else if (cell_idx != 3'd0 && in.hcount == next_at) begin
            if (cell_idx == 3'd4) begin
                char_code <= {5'b0, ASCII_SPC};
                char_xpos <= XPOS_12;
                cell_idx  <= '0;
            end else begin
                char_code <= {5'b0, digit_code[cell_idx[1:0]]};
                char_xpos <= next_at + LEAD_12;
                next_at   <= next_at + CELL_W;
                cell_idx  <= cell_idx + 3'd1;
            end
        end
    end

    assign char_ypos = 12'(YPOS);

endmodule

// File: tb/tb_digit_text_source.sv
// Bench for digit_text_source: three parameterisations scanned line by line against a
// per-cycle behavioural model, plus tabulated digit vectors and timing corner sequences.
module tb_digit_text_source;

    localparam int NDUT     = 3;
    localparam int LINE_LEN = 200;
    localparam int YPOS     = 5;
    localparam int LEAD     = 2;

    typedef struct packed {
        logic [13:0] value;
        logic [31:0] lz;
        logic [31:0] nb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value = '0;
    vga_if       vga();

    logic [11:0] code_o [NDUT];
    logic [11:0] xpos_o [NDUT];
    logic [11:0] ypos_o [NDUT];
    logic        busy_o [NDUT];

    int          checks = 0;
    int          errors = 0;
    int          cur_val, pend_val;
    bit          pend_valid;
    int          exp_code [NDUT];
    int          exp_xpos [NDUT];
    logic [31:0] cap_p1, cap_nb;
    int          cap_x1 [4];
    int          chg_p2 [$];
    vec_t        vecs [9];

    always #5 clk = ~clk;

    digit_text_source #(.XPOS(16), .YPOS(YPOS), .PRESCALER(1), .LEAD(LEAD), .BLANK_LZ(1)) u_p1 (
        .clk(clk), .rst(rst), .value(value), .in(vga),
        .char_code(code_o[0]), .char_xpos(xpos_o[0]), .char_ypos(ypos_o[0]), .busy(busy_o[0]));

    digit_text_source #(.XPOS(100), .YPOS(YPOS), .PRESCALER(2), .LEAD(LEAD), .BLANK_LZ(1)) u_p2 (
        .clk(clk), .rst(rst), .value(value), .in(vga),
        .char_code(code_o[1]), .char_xpos(xpos_o[1]), .char_ypos(ypos_o[1]), .busy(busy_o[1]));

    digit_text_source #(.XPOS(16), .YPOS(YPOS), .PRESCALER(1), .LEAD(LEAD), .BLANK_LZ(0)) u_nb (
        .clk(clk), .rst(rst), .value(value), .in(vga),
        .char_code(code_o[2]), .char_xpos(xpos_o[2]), .char_ypos(ypos_o[2]), .busy(busy_o[2]));

    function automatic int xp_of(input int d);
        return (d == 1) ? 100 : 16;
    endfunction

    function automatic int cw_of(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic bit bl_of(input int d);
        return (d != 2);
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    // Character for decimal position k (0 = thousands) of v.
    function automatic int digit_char(input int v, input int k, input bit bl);
        int p10;
        p10 = (k == 0) ? 1000 : (k == 1) ? 100 : (k == 2) ? 10 : 1;
        if (bl && k < 3 && v < p10) return 'h20;
        return 'h30 + (v / p10) % 10;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cur_val    = 0;
        pend_valid = 0;
        for (int d = 0; d < NDUT; d++) begin
            exp_code[d] = 'h20;
            exp_xpos[d] = xp_of(d);
        end
    endtask

    task automatic model_step(input int d, input int h, input int v);
        for (int k = 0; k <= 4; k++) begin
            if (h == xp_of(d) + k * cw_of(d) - LEAD) begin
                exp_code[d] = (k < 4) ? digit_char(v, k, bl_of(d)) : 'h20;
                exp_xpos[d] = (k < 4) ? xp_of(d) + k * cw_of(d) : xp_of(d);
            end
        end
    endtask

    // One scan line; optionally starts a conversion at hcount 0, re-pulses vblnk
    // (with a new value) at repulse_at, or asserts rst for one edge at rst_at.
    task automatic scan_line(input bit pulse, input int repulse_at, input int rst_at);
        int  v_used, prev_p2, nbusy;
        bit  exp_busy;
        if (pulse) begin
            pend_val   = sat(int'(value));
            pend_valid = 1;
        end
        nbusy   = 0;
        chg_p2.delete();
        prev_p2 = int'(code_o[1]);
        for (int h = 0; h < LINE_LEN; h++) begin
            vga.hcount = 12'(h);
            vga.vblnk  = (pulse && h == 0) || (h == repulse_at);
            rst        = (h == rst_at);
            if (h == repulse_at) value = 14'($urandom_range(0, 16383));
            @(negedge clk);
            if (h == rst_at) model_reset();
            else begin
                v_used = (pend_valid && h >= 17) ? pend_val : cur_val;
                for (int d = 0; d < NDUT; d++) model_step(d, h, v_used);
            end
            exp_busy = pend_valid && h >= 1 && h <= 15;
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("dut%0d char_code h=%0d", d, h), 32'(code_o[d]), 32'(exp_code[d]));
                check($sformatf("dut%0d char_xpos h=%0d", d, h), 32'(xpos_o[d]), 32'(exp_xpos[d]));
                check($sformatf("dut%0d busy h=%0d", d, h), 32'(busy_o[d]), 32'(exp_busy));
            end
            if (busy_o[0]) nbusy++;
            for (int k = 0; k < 4; k++) begin
                if (h == 16 + 8 * k - LEAD) begin
                    cap_p1[8*(3-k) +: 8] = code_o[0][7:0];
                    cap_nb[8*(3-k) +: 8] = code_o[2][7:0];
                    cap_x1[k]            = int'(xpos_o[0]);
                end
            end
            if (int'(code_o[1]) != prev_p2) begin
                chg_p2.push_back(h);
                prev_p2 = int'(code_o[1]);
            end
        end
        rst       = 1'b0;
        vga.vblnk = 1'b0;
        if (pend_valid) cur_val = pend_val;
        pend_valid = 0;
        if (pulse && rst_at < 0) check("busy cycle count", 32'(nbusy), 32'd15);
    endtask

    task automatic check_field(input string name, input logic [31:0] lz, input logic [31:0] nb);
        check({name, " blanked field"}, cap_p1, lz);
        check({name, " unblanked field"}, cap_nb, nb);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s xpos cell %0d", name, k), 32'(cap_x1[k]), 32'(16 + 8 * k));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{14'd1234,  32'h31323334, 32'h31323334};
        vecs[1] = '{14'd7,     32'h20202037, 32'h30303037};
        vecs[2] = '{14'd16383, 32'h39393939, 32'h39393939};
        vecs[3] = '{14'd0,     32'h20202030, 32'h30303030};
        vecs[4] = '{14'd10000, 32'h39393939, 32'h39393939};
        vecs[5] = '{14'd1005,  32'h31303035, 32'h31303035};
        vecs[6] = '{14'd50,    32'h20203530, 32'h30303530};
        vecs[7] = '{14'd305,   32'h20333035, 32'h30333035};
        vecs[8] = '{14'd4096,  32'h34303936, 32'h34303936};

        vga.hcount = 12'(LINE_LEN - 1);
        vga.vcount = '0;
        vga.vblnk  = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset dut%0d char_code", d), 32'(code_o[d]), 32'h20);
            check($sformatf("reset dut%0d char_xpos", d), 32'(xpos_o[d]), 32'(xp_of(d)));
            check($sformatf("reset dut%0d char_ypos", d), 32'(ypos_o[d]), 32'(YPOS));
            check($sformatf("reset dut%0d busy", d), 32'(busy_o[d]), 32'd0);
        end
        model_reset();
        scan_line(0, -1, -1);
        check_field("reset", 32'h20202030, 32'h30303030);

        for (int i = 0; i < 9; i++) begin
            value = vecs[i].value;
            scan_line(1, -1, -1);
            scan_line(0, -1, -1);
            check_field($sformatf("value %0d", vecs[i].value), vecs[i].lz, vecs[i].nb);
        end

        // Cell timing at PRESCALER=2, XPOS=100: changes after hcount 98,114,130,146,162.
        value = 14'd1234;
        scan_line(1, -1, -1);
        scan_line(0, -1, -1);
        check("p2 change count", 32'(chg_p2.size()), 32'd5);
        for (int i = 0; i < chg_p2.size() && i < 5; i++)
            check($sformatf("p2 change %0d hcount", i), 32'(chg_p2[i]), 32'(98 + 16 * i));

        // A second trigger and a new value while busy are both ignored.
        value = 14'd4321;
        scan_line(1, 5, -1);
        scan_line(0, -1, -1);
        check_field("dropped trigger", 32'h34333231, 32'h34333231);

        // Reset at T+8 aborts the conversion without committing.
        value = 14'd8888;
        scan_line(1, -1, 8);
        scan_line(0, -1, -1);
        check_field("reset mid-conversion", 32'h20202030, 32'h30303030);

        for (int i = 0; i < 12; i++) begin
            value = 14'($urandom_range(0, 16383));
            scan_line(1, -1, -1);
            scan_line(0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
